// File: rtl/sub_result_bcd_conv.sv
// -----------------------------------------------------------------------------
// sub_result_bcd_conv
//
// Sequential binary-to-BCD converter that sits directly after the 9-bit ripple
// subtractor. It takes the subtractor difference and borrow and splits them
// into a sign and a magnitude. It then converts the magnitude into DIGITS BCD
// digits using double-dabble (add-3, then shift), one magnitude bit per clock.
//
// Ports
//   clk     in   1          single clock, rising edge
//   rst     in   1          synchronous active-high reset (also aborts a run)
//   start   in   1          conversion request, sampled only while idle
//   diff    in   WIDTH      subtractor difference (two's-complement low bits)
//   borrow  in   1          subtractor borrow, 1 = result negative
//   bcd     out  4*DIGITS   result digits, [3:0]=ones, [7:4]=tens, ...
//   neg     out  1          result sign, 1 = negative (never negative zero)
//   busy    out  1          conversion in progress
//   done    out  1          one-cycle pulse, bcd/neg were just updated
//   blank   out  DIGITS     leading-zero blanking flags
//                           (present only with BCD_LEADING_ZERO_BLANK_EN)
//
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN
//   When defined, the module adds the blank port. It is loaded together with
//   bcd. blank[i] is set when digit i and every higher digit are zero. The
//   ones digit is never blanked.
//
// Timing: start accepted on edge E0 -> done and new bcd after edge E0+WIDTH.
// -----------------------------------------------------------------------------
module sub_result_bcd_conv #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    diff,
    input  logic                borrow,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic                busy,
    output logic                done
`ifdef BCD_LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_scratch;
    logic [CW-1:0]    r_count;
    logic             r_neg_pend;
    logic [BW-1:0]    r_bcd;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_mag_in;
    logic             w_neg_in;
    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_scratch_next;
    logic [WIDTH-1:0] w_mag_next;

    // Magnitude of the subtraction result. The borrow means the difference
    // bits are the two's complement of |x-y|, so negate them modulo 2**WIDTH.
    assign w_mag_in = borrow ? (~diff + WIDTH'(1)) : diff;
    // A zero magnitude is always reported positive.
    assign w_neg_in = borrow & (w_mag_in != '0);

    // Add-3 correction. Any digit of 5 or more would reach 10 or more after
    // the shift, so pre-adding 3 makes the shift carry into the next digit.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                    ? (r_scratch[4*gi +: 4] + 4'd3)
                                    : r_scratch[4*gi +: 4];
        end
    endgenerate

    // Shift {scratch, mag} left by one. The MSB of the magnitude enters the
    // ones digit.
    assign w_scratch_next = {w_adj[BW-2:0], r_mag[WIDTH-1]};
    assign w_mag_next     = {r_mag[WIDTH-2:0], 1'b0};

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] r_blank;

    // The ones digit is always shown, so that a value of 0 still displays.
    assign w_blank[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_blank[gi] = (w_scratch_next[BW-1:4*gi] == '0);
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mag      <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_neg_pend <= 1'b0;
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            r_blank    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_mag      <= w_mag_in;
                    r_neg_pend <= w_neg_in;
                    r_scratch  <= '0;
                    r_count    <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= ST_SHIFT;
                end
            end else begin
                r_scratch <= w_scratch_next;
                r_mag     <= w_mag_next;
                r_count   <= r_count + CW'(1);
                // This edge performs the final shift. Publish the result
                // here so the outputs never show a partial value.
                if (r_count == LAST_CNT) begin
                    r_bcd   <= w_scratch_next;
                    r_neg   <= r_neg_pend;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                    r_blank <= w_blank;
`endif
                end
            end
        end
    end

    assign bcd  = r_bcd;
    assign neg  = r_neg;
    assign busy = r_busy;
    assign done = r_done;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    assign blank = r_blank;
`endif

endmodule
